sbox_state_sequencer: RTL and testbench

- Host-side engine for the 4-share first-order AES S-box path.
- Accepts a 4-share 128-bit masked state and streams it one byte per cycle into an external two_stage_sbox instance, forwarding fresh randomness with each byte.
- Collects the S-box output shares after the pipeline latency and returns the 4-share 128-bit SubBytes result over a valid/ready handshake.
- It is the driver and collector at both ends of the S-box byte interface, used by the serial round datapath.

---
 rtl/sbox_state_sequencer_pkg.sv | 16 +
 rtl/share_byte_shreg.sv | 37 +++
 rtl/sbox_state_sequencer.sv | 133 +++++++++++++
 tb/tb_sbox_state_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_state_sequencer_pkg.sv
// Shared definitions for the 4-share masked S-box sequencer.
// Holds share/byte geometry and the sequencer FSM encoding.
package sbox_state_sequencer_pkg;
   localparam int NUM_SHARES = 4;
   localparam int NBYTES     = 16;
   localparam int BYTE_W     = 8;
   localparam int R_W        = 64;
   localparam int STATE_W    = NBYTES * BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;
endpackage

// File: rtl/share_byte_shreg.sv
// One 128-bit share register with parallel load and byte shift.
// Shifting moves every byte one position down (byte 1 -> byte 0) and
// inserts shift_in at byte 15, so byte 0 leaves first and the first
// byte shifted in ends up lowest after a full pass.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load/load_val parallel load (has priority over shift)
//   shift/shift_in byte shift enable and incoming top byte
//   q             register contents
module share_byte_shreg
   import sbox_state_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [STATE_W-1:0] load_val,
   input  logic               shift,
   input  logic [BYTE_W-1:0]  shift_in,
   output logic [STATE_W-1:0] q
);
   logic [STATE_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load)
         q_d = load_val;
      else if (shift)
         q_d = {shift_in, q_q[STATE_W-1:BYTE_W]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/sbox_state_sequencer.sv
// Drives a 4-share masked state byte-serially into an external S-box
// pipeline and collects the SubBytes result shares.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   in_valid/in_ready        masked state handshake (ready only in IDLE)
//   in_sh0..3                input shares, byte i = bits [8i+7:8i]
//   rnd_in                   fresh randomness, forwarded while feeding
//   out_valid/out_ready      result handshake, result held until taken
//   out_sh0..3               registered result shares
//   sb_in0..3, sb_r          byte/randomness towards the S-box
//   sb_out0..3               result bytes from the S-box
// Each share keeps its own register and path; shares are never combined.
module sbox_state_sequencer
   import sbox_state_sequencer_pkg::*;
#(
   parameter int SBOX_LAT = 2
)(
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_sh0,
   input  logic [STATE_W-1:0] in_sh1,
   input  logic [STATE_W-1:0] in_sh2,
   input  logic [STATE_W-1:0] in_sh3,
   input  logic [R_W-1:0]     rnd_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_sh0,
   output logic [STATE_W-1:0] out_sh1,
   output logic [STATE_W-1:0] out_sh2,
   output logic [STATE_W-1:0] out_sh3,
   output logic [BYTE_W-1:0]  sb_in0,
   output logic [BYTE_W-1:0]  sb_in1,
   output logic [BYTE_W-1:0]  sb_in2,
   output logic [BYTE_W-1:0]  sb_in3,
   output logic [R_W-1:0]     sb_r,
   input  logic [BYTE_W-1:0]  sb_out0,
   input  logic [BYTE_W-1:0]  sb_out1,
   input  logic [BYTE_W-1:0]  sb_out2,
   input  logic [BYTE_W-1:0]  sb_out3
);
   localparam int CW = $clog2(NBYTES);
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   state_e state_q, state_d;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;
   logic [CW-1:0] cap_cnt_q, cap_cnt_d;
   // vld_pipe[0] marks a byte entering the S-box; the top tap marks its
   // result arriving on sb_out, which is exactly when it is captured.
   logic [SBOX_LAT:0]   vld_pipe;
   logic [SBOX_LAT-1:0] vld_pipe_q, vld_pipe_d;
   logic feed, accept, cap_en;

   logic [NUM_SHARES-1:0][STATE_W-1:0] in_sh, in_q, out_q;
   logic [NUM_SHARES-1:0][BYTE_W-1:0]  sb_o;

   assign in_sh = {in_sh3, in_sh2, in_sh1, in_sh0};
   assign sb_o  = {sb_out3, sb_out2, sb_out1, sb_out0};

   assign feed     = (state_q == ST_FEED);
   assign accept   = (state_q == ST_IDLE) && in_valid;
   assign vld_pipe = {vld_pipe_q, feed};
   assign cap_en   = vld_pipe_q[SBOX_LAT-1];

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      vld_pipe_d = vld_pipe[SBOX_LAT-1:0];
      // capture counter runs on its own, saturating at the last byte
      if (cap_en && cap_cnt_q != LAST)
         cap_cnt_d = cap_cnt_q + 1'b1;
      case (state_q)
         ST_IDLE: if (in_valid) begin
            state_d    = ST_FEED;
            byte_cnt_d = '0;
            cap_cnt_d  = '0;
         end
         ST_FEED: begin
            if (byte_cnt_q == LAST) state_d = ST_DRAIN;
            else                    byte_cnt_d = byte_cnt_q + 1'b1;
         end
         // the last capture edge is the HOLD entry edge
         ST_DRAIN: if (cap_en && cap_cnt_q == LAST) state_d = ST_HOLD;
         ST_HOLD:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         cap_cnt_q  <= '0;
         vld_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   for (genvar k = 0; k < NUM_SHARES; k++) begin : g_sh
      share_byte_shreg u_in (
         .clk(CLK), .rst(RST),
         .load(accept), .load_val(in_sh[k]),
         .shift(feed), .shift_in(BYTE_W'(0)),
         .q(in_q[k])
      );
      share_byte_shreg u_out (
         .clk(CLK), .rst(RST),
         .load(1'b0), .load_val(STATE_W'(0)),
         .shift(cap_en), .shift_in(sb_o[k]),
         .q(out_q[k])
      );
   end

   assign in_ready  = (state_q == ST_IDLE) && !RST;
   assign out_valid = (state_q == ST_HOLD);

   assign out_sh0 = out_q[0];
   assign out_sh1 = out_q[1];
   assign out_sh2 = out_q[2];
   assign out_sh3 = out_q[3];

   assign sb_in0 = feed ? in_q[0][BYTE_W-1:0] : '0;
   assign sb_in1 = feed ? in_q[1][BYTE_W-1:0] : '0;
   assign sb_in2 = feed ? in_q[2][BYTE_W-1:0] : '0;
   assign sb_in3 = feed ? in_q[3][BYTE_W-1:0] : '0;
   assign sb_r   = feed ? rnd_in : '0;
endmodule

// File: tb/tb_sbox_state_sequencer.sv
module tb_sbox_state_sequencer;
   typedef logic [3:0][127:0] shares_t;

   logic CLK, RST;
   logic [63:0] rnd_in;
   logic [1:0] in_valid, in_ready, out_valid, out_ready;
   logic [1:0][3:0][127:0] in_sh, out_sh;
   logic [1:0][3:0][7:0] sb_in, sb_out;
   logic [1:0][63:0] sb_r;

   int tests = 0;
   int fails = 0;

   // ---------------- AES S-box reference (GF(2^8) inverse + affine) -----
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv, base, e;
      inv = 8'h01; base = x; e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) inv = gmul(inv, base);
         base = gmul(base, base);
      end
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(v[8*i +: 8]);
      return r;
   endfunction

   function automatic shares_t mask_state(input logic [127:0] p);
      shares_t s;
      for (int j = 0; j < 3; j++) s[j] = {$urandom, $urandom, $urandom, $urandom};
      s[3] = p ^ s[0] ^ s[1] ^ s[2];
      return s;
   endfunction

   // ---------------- DUTs with behavioural masked S-box models ----------
   for (genvar d = 0; d < 2; d++) begin : g_dut
      localparam int L = 2 + d;
      logic [7:0]  y;
      logic [23:0] msk = 24'h5a3c96;
      logic [31:0] pipe [L];

      assign y = sbox(sb_in[d][0] ^ sb_in[d][1] ^ sb_in[d][2] ^ sb_in[d][3]);
      always @(posedge CLK) begin
         msk     <= 24'($urandom);
         pipe[0] <= {y ^ msk[23:16] ^ msk[15:8] ^ msk[7:0], msk};
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign sb_out[d] = pipe[L-1];

      sbox_state_sequencer #(.SBOX_LAT(L)) u_dut (
         .CLK(CLK), .RST(RST),
         .in_valid(in_valid[d]), .in_ready(in_ready[d]),
         .in_sh0(in_sh[d][0]), .in_sh1(in_sh[d][1]),
         .in_sh2(in_sh[d][2]), .in_sh3(in_sh[d][3]),
         .rnd_in(rnd_in),
         .out_valid(out_valid[d]), .out_ready(out_ready[d]),
         .out_sh0(out_sh[d][0]), .out_sh1(out_sh[d][1]),
         .out_sh2(out_sh[d][2]), .out_sh3(out_sh[d][3]),
         .sb_in0(sb_in[d][0]), .sb_in1(sb_in[d][1]),
         .sb_in2(sb_in[d][2]), .sb_in3(sb_in[d][3]),
         .sb_r(sb_r[d]),
         .sb_out0(sb_out[d][0]), .sb_out1(sb_out[d][1]),
         .sb_out2(sb_out[d][2]), .sb_out3(sb_out[d][3])
      );
   end

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // fresh randomness every cycle
   initial begin
      rnd_in = 64'h0123_4567_89ab_cdef;
      forever begin
         @(posedge CLK);
         #1 rnd_in = {$urandom, $urandom};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic accept(input int d, input shares_t s);
      @(negedge CLK);
      in_sh[d]    = s;
      in_valid[d] = 1'b1;
      chk("accept_in_ready", 128'(in_ready[d]), 128'd1);
      @(posedge CLK);
   endtask

   // Called just after the accept edge. Walks the operation cycle by
   // cycle, checking the S-box bus against the shares fed, and returns
   // the unmasked result once out_valid is seen.
   task automatic collect(input int d, input int lat, input shares_t s,
                          input bit keep, output logic [127:0] ures);
      int lat_obs = -1;
      int bad = 0;
      logic [127:0] sh, ux, exp;
      logic [7:0] eb;
      ux  = s[0] ^ s[1] ^ s[2] ^ s[3];
      exp = sub_bytes(ux);
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (k == 0 && !keep) in_valid[d] = 1'b0;
         for (int j = 0; j < 4; j++) begin
            sh = s[j] >> (8 * k);
            eb = (k < 16) ? sh[7:0] : 8'h00;
            if (sb_in[d][j] !== eb) bad++;
         end
         if (sb_r[d] !== ((k < 16) ? rnd_in : 64'h0)) bad++;
         if (in_ready[d] !== 1'b0) bad++;
         if (out_valid[d] === 1'b1) begin
            lat_obs = k;
            break;
         end
      end
      chk("latency", 128'(lat_obs), 128'(lat));
      chk("sbox_bus", 128'(bad), 128'd0);
      ures = out_sh[d][0] ^ out_sh[d][1] ^ out_sh[d][2] ^ out_sh[d][3];
      chk("result", ures, exp);
      for (int j = 0; j < 4; j++)
         chk("share_masked", 128'(out_sh[d][j] === exp), 128'd0);
   endtask

   task automatic release_out(input int d, input shares_t snap);
      @(negedge CLK);
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      @(negedge CLK);
      chk("rel_out_valid", 128'(out_valid[d]), 128'd0);
      chk("rel_in_ready", 128'(in_ready[d]), 128'd1);
      chk("rel_out_keep", out_sh[d] ^ snap, 128'd0);
      out_ready[d] = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      shares_t s, s2, snap;
      logic [127:0] p, res;
      int bad;

      RST = 1'b1;
      in_valid = '0; out_ready = '0; in_sh = '0;
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_sh", out_sh[0] | out_sh[1], 128'd0);
      chk("rst_sb", {sb_in, sb_r[0]}, 128'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("idle_in_ready", 128'(in_ready), 128'd3);

      // 1) all-zero state, consumer always ready
      out_ready[0] = 1'b1;
      s = '0;
      accept(0, s);
      collect(0, 18, s, 1'b0, res);
      chk("zero_state", res, {16{8'h63}});
      @(negedge CLK);
      chk("zero_done_valid", 128'(out_valid[0]), 128'd0);
      chk("zero_done_ready", 128'(in_ready[0]), 128'd1);
      out_ready[0] = 1'b0;

      // 2) byte i = i, random masking, then backpressure in HOLD
      for (int i = 0; i < 16; i++) p[8*i +: 8] = 8'(i);
      s = mask_state(p);
      accept(0, s);
      collect(0, 18, s, 1'b0, res);
      chk("known_bytes", 128'({res[127:120], res[31:0]}), 128'h76_7b777c63);
      snap = out_sh[0];
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         in_valid[0] = (i % 2 == 0);
         in_sh[0]    = mask_state({$urandom, $urandom, $urandom, $urandom});
         #1;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_sh[0] !== snap) bad++;
      end
      chk("backpressure", 128'(bad), 128'd0);
      release_out(0, snap);

      // 3) three-cycle S-box pipeline
      s = mask_state({$urandom, $urandom, $urandom, $urandom});
      accept(1, s);
      collect(1, 19, s, 1'b0, res);
      release_out(1, out_sh[1]);

      // 4) reset during feed byte 7
      s = mask_state({$urandom, $urandom, $urandom, $urandom});
      accept(0, s);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (k == 0) in_valid[0] = 1'b0;
      end
      RST = 1'b1;
      #1;
      chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
      chk("abort_sb", {sb_in[0], sb_r[0]}, 128'd0);
      chk("abort_in_ready", 128'(in_ready[0]), 128'd0);
      chk("abort_out_sh", out_sh[0], 128'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("abort_release_ready", 128'(in_ready[0]), 128'd1);
      bad = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge CLK);
         if (out_valid[0] !== 1'b0 || sb_in[0] !== 32'h0 || sb_r[0] !== 64'h0) bad++;
      end
      chk("abort_quiet", 128'(bad), 128'd0);
      s = mask_state({$urandom, $urandom, $urandom, $urandom});
      accept(0, s);
      collect(0, 18, s, 1'b0, res);
      release_out(0, out_sh[0]);

      // 5) back-to-back: in_valid held high, consumer always ready
      s  = mask_state({$urandom, $urandom, $urandom, $urandom});
      s2 = mask_state({$urandom, $urandom, $urandom, $urandom});
      out_ready[0] = 1'b1;
      accept(0, s);
      collect(0, 18, s, 1'b1, res);
      in_sh[0] = s2;
      @(negedge CLK);
      chk("b2b_gap_ready", 128'(in_ready[0]), 128'd1);
      chk("b2b_gap_valid", 128'(out_valid[0]), 128'd0);
      @(posedge CLK);
      collect(0, 18, s2, 1'b0, res);
      @(negedge CLK);
      chk("b2b_done_valid", 128'(out_valid[0]), 128'd0);
      out_ready[0] = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
